// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state type and special-case result constants.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the EX stage and the multiply/divide unit.
// master: pipeline side; slave: the unit.
interface muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr;
   logic            flush;
   logic            busy;
   logic            done;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;

   modport master (
      output start, op, rs1_data, rs2_data, rd_addr, flush,
      input  busy, done, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  start, op, rs1_data, rs2_data, rd_addr, flush,
      output busy, done, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Converts the unsigned magnitude result of the iteration core into the final
// signed/unsigned RV32M result selected by op.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2*XLEN-1:0] raw,
   input  logic              neg_a,
   input  logic              neg_b,
   input  logic [2:0]        op,
   output logic [XLEN-1:0]   result
);
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;

   // raw holds the product for multiplies, {remainder, quotient} for divides
   always_comb begin
      prod = (neg_a ^ neg_b) ? -raw : raw;
      quot = (neg_a ^ neg_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
      rem  = neg_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
      case (op)
         OP_MUL:                       result = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result = quot;
         default:                      result = rem;
      endcase
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide
// sharing one accumulator, with a one-cycle register-file write request on completion.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic      clk,
   input logic      rst,
   muldiv_if.slave  bus
);
   localparam int unsigned CntW = $clog2(XLEN);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]   wr_data_q, wr_data_d;

   logic              signed_a, signed_b;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN-1:0]   special_res;
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_rem;
   logic [XLEN-1:0]   div_diff;
   logic [XLEN-1:0]   fixed_res;

   // Operand decode at issue time
   always_comb begin
      signed_a = bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      signed_b = bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      mag_a    = (signed_a && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
      mag_b    = (signed_b && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
      div_zero = bus.op[2] && (bus.rs2_data == '0);
      div_ovf  = (bus.op == OP_DIV || bus.op == OP_REM) &&
                 (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
      if (div_zero) begin
         special_res = bus.op[1] ? bus.rs1_data : DIV0_QUOT;
      end else begin
         special_res = bus.op[1] ? '0 : INT_MIN;
      end
   end

   // One iteration; the remainder compare needs 33 bits since the divisor may exceed 2^31
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_rem  = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_rem[XLEN-1:0] - b_q;
      if (op_q[2]) begin
         if (div_rem >= {1'b0, b_q}) begin
            step_acc = {div_diff, acc_q[XLEN-2:0], 1'b1};
         end else begin
            step_acc = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step_acc = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   muldiv_sign_fix #(
      .XLEN (XLEN)
   ) u_sign_fix (
      .raw    (step_acc),
      .neg_a  (neg_a_q),
      .neg_b  (neg_b_q),
      .op     (op_q),
      .result (fixed_res)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      acc_d     = acc_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.flush) begin
               op_d    = bus.op;
               rd_d    = bus.rd_addr;
               neg_a_d = signed_a & bus.rs1_data[XLEN-1];
               neg_b_d = signed_b & bus.rs2_data[XLEN-1];
               acc_d   = {{XLEN{1'b0}}, mag_a};
               b_d     = mag_b;
               cnt_d   = '0;
               if (div_zero || div_ovf) begin
                  wr_data_d = special_res;
                  state_d   = StDone;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1 && !bus.flush) begin
               wr_data_d = fixed_res;
               state_d   = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.flush) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         rd_q      <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         acc_q     <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.busy    = (state_q == StBusy);
   assign bus.done    = (state_q == StDone);
   assign bus.wr_en   = (state_q == StDone) && (rd_q != '0);
   assign bus.wr_addr = rd_q;
   assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latencies, rd=0,
// ignored restarts, flush and reset behaviour.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   muldiv_if #(.XLEN(32)) bus ();

   muldiv_unit #(
      .XLEN (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; accept happens at the next posedge (edge 0).
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_cyc, input bit hold);
      int cyc = 0;
      int busy_cyc = 0;
      int extra = 0;
      bus.start    = 1'b1;
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_addr  = rd;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            cyc = k;
            break;
         end
         if (bus.busy) busy_cyc++;
      end
      check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_cyc - 1));
      check({tag, " wr_data"}, bus.wr_data, exp_data);
      check({tag, " wr_addr"}, {27'd0, bus.wr_addr}, {27'd0, rd});
      check({tag, " wr_en"}, {31'd0, bus.wr_en}, {31'd0, rd != 5'd0});
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.wr_en) extra++;
      end
      check({tag, " idle_after"}, 32'(extra), 32'd0);
   endtask

   initial begin
      int bad;
      bus.start    = 1'b0;
      bus.op       = 3'd0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.rd_addr  = '0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset wr_en", {31'd0, bus.wr_en}, 32'd0);
      check("reset wr_addr", {27'd0, bus.wr_addr}, 32'd0);
      check("reset wr_data", bus.wr_data, 32'd0);
      rst = 1'b0;

      run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b0);
      run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, 1'b0);
      run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, 1'b0);
      run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 33,
             1'b0);
      run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, 1'b0);
      run_op("divu", OP_DIVU, 32'd7, 32'd2, 5'd12, 32'd3, 33, 1'b0);
      run_op("remu", OP_REMU, 32'd7, 32'd2, 5'd13, 32'd1, 33, 1'b0);
      run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd14, 32'd1, 33, 1'b0);
      run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd15, 32'h7FFF_FFFF, 33,
             1'b0);

      run_op("div_by0", OP_DIV, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 1, 1'b0);
      run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd17, 32'd5, 1, 1'b0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1, 1'b0);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 1, 1'b0);

      // rd=0 with start held through BUSY: exactly one completion, no write
      run_op("rd0_hold", OP_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 33, 1'b1);

      // Flush at cycle 10 of a DIV
      bus.start    = 1'b1;
      bus.op       = OP_DIV;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd3;
      bus.rd_addr  = 5'd20;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bad = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.done || bus.wr_en || !bus.busy) bad++;
      end
      check("flush busy_before", 32'(bad), 32'd0);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("flush busy", {31'd0, bus.busy}, 32'd0);
      check("flush done", {31'd0, bus.done}, 32'd0);
      check("flush wr_en", {31'd0, bus.wr_en}, 32'd0);
      run_op("div_after_flush", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0);

      // Reset at cycle 20 of a MUL
      bus.start    = 1'b1;
      bus.op       = OP_MUL;
      bus.rs1_data = 32'h0000_1234;
      bus.rs2_data = 32'd3;
      bus.rd_addr  = 5'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
      check("rst wr_en", {31'd0, bus.wr_en}, 32'd0);
      check("rst wr_addr", {27'd0, bus.wr_addr}, 32'd0);
      check("rst wr_data", bus.wr_data, 32'd0);
      rst = 1'b0;
      run_op("mul_after_rst", OP_MUL, 32'h0000_1234, 32'd3, 5'd9, 32'h0000_369C, 33, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. Consumes the two operands read from the register file plus the destination index, runs a 32-step shift-add multiply or restoring divide, and drives a one-cycle write request back to the register-file write port. The pipeline hazard logic stalls on `busy`; `flush` squashes the operation on branch/exception redirect.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `clk`: input, 1 bit. Rising-edge clock.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `start`: input, 1 bit. Request a new operation. Accepted only in IDLE.
- `op`: input, 3 bits. funct3 encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rs1_data`: input, 32 bits. Operand A / dividend.
- `rs2_data`: input, 32 bits. Operand B / divisor.
- `rd_addr`: input, 5 bits. Destination register index.
- `flush`: input, 1 bit. Abort any in-flight operation.
- `busy`: output, 1 bit. High in BUSY.
- `done`: output, 1 bit. One-cycle pulse in DONE.
- `wr_en`: output, 1 bit. Register write enable. Equals `done && wr_addr != 0`.
- `wr_addr`: output, 5 bits. Latched `rd_addr`.
- `wr_data`: output, 32 bits. Result. Held stable from DONE until the next accept.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE to BUSY: on `start && !flush`. Latch `op`, `rd_addr`, operand magnitudes and sign flags. Clear the step counter.
  - IDLE to DONE: on a special-case divide (see below). The result is computed and latched directly.
  - BUSY: one iteration per cycle. After the step with counter == 31, go to DONE.
  - DONE to IDLE: unconditionally, after one cycle.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Sign handling: the core operates on absolute values.
  - Product negated when operand signs differ.
  - Quotient negated when signs differ.
  - Remainder takes the sign of the dividend.
  - The sign fix is applied when latching `wr_data` on entry to DONE.
- Multiply result selection:
  - MUL returns product bits [31:0].
  - MULH, MULHSU, MULHU return product bits [63:32] of the 64-bit product.
- Divide special cases (no iteration):
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend. Applies to both signed and unsigned forms.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- `start` arriving in BUSY or DONE is ignored. The hazard unit must keep the instruction stalled and re-present it.
- `flush` in any state: next state is IDLE, and `done`/`wr_en` stay low. `flush` wins over a simultaneous `start`.
  - `flush` in the DONE cycle does not suppress that cycle's write; it is already committed.
- `rst` mid-operation: identical to `flush`, and additionally clears all registers.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- Normal latency: accept at edge N. `busy` is high for cycles N+1..N+32. `done` and `wr_en` are high in cycle N+33. The unit is back in IDLE at N+34 and can accept a new `start` at the edge ending cycle N+34.
- Special-case latency: accept at edge N, `done` in cycle N+1.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- `wr_data` timing relative to the register file: it is valid for the whole DONE cycle, so the register file's write commits inside that cycle.

## Structure
- Shared package `muldiv_pkg` contains:
  - the `op` funct3 localparams;
  - the state enum (IDLE/BUSY/DONE);
  - the constants DIV0_QUOT = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- One combinational sub-module, `muldiv_sign_fix`. Inputs are raw 64-bit product/quotient/remainder, sign flags and `op`. Output is the final 32-bit result.
- Iteration registers live in `muldiv_unit` and are shared between multiply and divide:
  - 64-bit accumulator / remainder:quotient pair;
  - 32-bit operand B;
  - 5-bit counter.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5, accept at edge 0: `busy` cycles 1–32; cycle 33 `done`=1, `wr_en`=1, `wr_addr`=5, `wr_data`=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- Divides by 2 with dividend −7:
  - DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 gives 0xFFFFFFFF.
  - DIVU 7/2 gives 3.
  - REMU 7/2 gives 1.
  - Each has `done` at cycle 33.
- Special-case divides, each with `done` at cycle 1:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM of the same operands gives 0.
- rd=0: `done` pulses and `wr_en` stays 0. A second `start` held high during BUSY is ignored: exactly one `done` occurs, and the operation is accepted only after returning to IDLE.
- `flush` at cycle 10 of a DIV: IDLE at cycle 11, no `done` or `wr_en`, and a new `start` is accepted immediately. `rst` at cycle 20 of a MUL: all outputs 0 the next cycle.
